tx_frame_sequencer: RTL and testbench

TX_FRAME_SEQUENCER -- requirements
Module: tx_frame_sequencer

---
 rtl/tx_frame_sequencer.sv | 126 ++++++++++++
 tb/tb_tx_frame_sequencer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/tx_frame_sequencer.sv
// Serial transmit frame sequencer: START, DATA, optional PARITY, STOP, advanced by bit-period pulses.
// Optional PARITY phase compiled in with `define TX_PARITY_EN (default build: no parity).
//   phase | meaning
//   0     | IDLE   - waiting for start
//   1     | START  - start bit period
//   2     | DATA   - data bit periods, bit_idx 0..DATA_BITS-1
//   3     | PARITY - parity bit period (TX_PARITY_EN only)
//   4     | STOP   - stop bit periods, bit_idx 0..STOP_BITS-1
module tx_frame_sequencer #(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1,
  parameter int FCNT_W    = 8
) (
  input  logic              CLK,
  input  logic              SRST,
  input  logic              EN,
  input  logic              BitDone,
  input  logic              tx_en,
  input  logic              BYCRST,
  input  logic              start,
  output logic [3:0]        bit_idx,
  output logic [2:0]        phase,
  output logic              busy,
  output logic              frame_done,
  output logic [FCNT_W-1:0] frame_cnt
);

  localparam logic [2:0] PH_IDLE   = 3'd0;
  localparam logic [2:0] PH_START  = 3'd1;
  localparam logic [2:0] PH_DATA   = 3'd2;
  localparam logic [2:0] PH_PARITY = 3'd3;
  localparam logic [2:0] PH_STOP   = 3'd4;

`ifdef TX_PARITY_EN
  localparam logic [2:0] PH_DATA_EXIT = PH_PARITY;
`else
  localparam logic [2:0] PH_DATA_EXIT = PH_STOP;
`endif

  localparam logic [3:0] DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);

  logic [2:0]        phase_q, phase_d;
  logic [3:0]        idx_q, idx_d;
  logic              busy_q;
  logic              done_q, done_d;
  logic [FCNT_W-1:0] cnt_q, cnt_d;
  logic              adv;

  assign adv = EN & BitDone & tx_en;

  always_ff @(posedge CLK) begin
    if (SRST) begin
      phase_q <= PH_IDLE;
      idx_q   <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      phase_q <= phase_d;
      idx_q   <= idx_d;
      busy_q  <= (phase_d != PH_IDLE);
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    phase_d = phase_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    if (!BYCRST) begin
      phase_d = PH_IDLE;
      idx_d   = 4'd0;
    end else if (phase_q == PH_IDLE) begin
      // adv has no meaning in IDLE, so only start can leave it
      if (start && tx_en) begin
        phase_d = PH_START;
        idx_d   = 4'd0;
      end
    end else if (adv) begin
      case (phase_q)
        PH_START: begin
          phase_d = PH_DATA;
          idx_d   = 4'd0;
        end
        PH_DATA: begin
          if (idx_q == DATA_LAST) begin
            phase_d = PH_DATA_EXIT;
            idx_d   = 4'd0;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
        PH_PARITY: begin
          phase_d = PH_STOP;
          idx_d   = 4'd0;
        end
        PH_STOP: begin
          if (idx_q == STOP_LAST) begin
            phase_d = PH_IDLE;
            idx_d   = 4'd0;
            done_d  = 1'b1;
            cnt_d   = cnt_q + 1'b1;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
        default: begin
          phase_d = PH_IDLE;
          idx_d   = 4'd0;
        end
      endcase
    end
  end

  always_comb begin
    phase      = phase_q;
    bit_idx    = idx_q;
    busy       = busy_q;
    frame_done = done_q;
    frame_cnt  = cnt_q;
  end

endmodule

// File: tb/tb_tx_frame_sequencer.sv
// Bench for tx_frame_sequencer: two configurations driven in lockstep against a frame-position model.
// Honours TX_PARITY_EN the same way the design does.
module tb_tx_frame_sequencer;

`ifdef TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  localparam int DA = 8, SA = 1, WA = 2;
  localparam int DB = 5, SB = 2, WB = 8;

  logic clk = 1'b0;
  logic srst, en, bd, txen, byc, st;
  logic [3:0]    idx_a, idx_b;
  logic [2:0]    ph_a, ph_b;
  logic          busy_a, busy_b, done_a, done_b;
  logic [WA-1:0] cnt_a;
  logic [WB-1:0] cnt_b;

  always #5 clk = ~clk;

  tx_frame_sequencer #(.DATA_BITS(DA), .STOP_BITS(SA), .FCNT_W(WA)) dut_a (
    .CLK(clk), .SRST(srst), .EN(en), .BitDone(bd), .tx_en(txen), .BYCRST(byc), .start(st),
    .bit_idx(idx_a), .phase(ph_a), .busy(busy_a), .frame_done(done_a), .frame_cnt(cnt_a));

  tx_frame_sequencer #(.DATA_BITS(DB), .STOP_BITS(SB), .FCNT_W(WB)) dut_b (
    .CLK(clk), .SRST(srst), .EN(en), .BitDone(bd), .tx_en(txen), .BYCRST(byc), .start(st),
    .bit_idx(idx_b), .phase(ph_b), .busy(busy_b), .frame_done(done_b), .frame_cnt(cnt_b));

  // Model: pos 0 = idle, otherwise 1-based number of the bit period in progress
  int m_pos[2], m_cnt[2], m_done[2];
  int m_d[2] = '{DA, DB};
  int m_n[2] = '{1 + DA + PAR + SA, 1 + DB + PAR + SB};
  int m_w[2] = '{WA, WB};

  int n_checks = 0, n_pass = 0, done_seen = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  function automatic int exp_phase(int i);
    int p = m_pos[i];
    if (p == 0) return 0;
    if (p == 1) return 1;
    if (p <= 1 + m_d[i]) return 2;
    if (PAR == 1 && p == 2 + m_d[i]) return 3;
    return 4;
  endfunction

  function automatic int exp_idx(int i);
    int p = m_pos[i];
    if (p <= 1) return 0;
    if (p <= 1 + m_d[i]) return p - 2;
    if (PAR == 1 && p == 2 + m_d[i]) return 0;
    return p - (2 + m_d[i] + PAR);
  endfunction

  task automatic model_step(input bit s_rst, input bit s_adv, input bit s_byc, input bit s_go);
    for (int i = 0; i < 2; i++) begin
      m_done[i] = 0;
      if (s_rst) begin
        m_pos[i] = 0;
        m_cnt[i] = 0;
      end else if (!s_byc) begin
        m_pos[i] = 0;
      end else if (m_pos[i] != 0 && s_adv) begin
        if (m_pos[i] == m_n[i]) begin
          m_pos[i]  = 0;
          m_done[i] = 1;
          m_cnt[i]  = (m_cnt[i] + 1) % (1 << m_w[i]);
        end else begin
          m_pos[i]++;
        end
      end else if (m_pos[i] == 0 && s_go) begin
        m_pos[i] = 1;
      end
    end
  endtask

  task automatic compare_all();
    check("a_phase", int'(ph_a), exp_phase(0));
    check("a_bit_idx", int'(idx_a), exp_idx(0));
    check("a_busy", int'(busy_a), int'(m_pos[0] != 0));
    check("a_frame_done", int'(done_a), m_done[0]);
    check("a_frame_cnt", int'(cnt_a), m_cnt[0]);
    check("b_phase", int'(ph_b), exp_phase(1));
    check("b_bit_idx", int'(idx_b), exp_idx(1));
    check("b_busy", int'(busy_b), int'(m_pos[1] != 0));
    check("b_frame_done", int'(done_b), m_done[1]);
    check("b_frame_cnt", int'(cnt_b), m_cnt[1]);
  endtask

  task automatic drive(input bit i_rst, input bit i_en, input bit i_bd, input bit i_tx,
                       input bit i_byc, input bit i_st);
    srst = i_rst; en = i_en; bd = i_bd; txen = i_tx; byc = i_byc; st = i_st;
    model_step(i_rst, i_en & i_bd & i_tx, i_byc, i_st & i_tx);
    @(negedge clk);
    if (done_a) done_seen++;
    compare_all();
  endtask

  task automatic idle_cyc();  drive(0, 1, 0, 1, 1, 0); endtask
  task automatic adv_cyc();   drive(0, 1, 1, 1, 1, 0); endtask
  task automatic start_cyc(); drive(0, 1, 0, 1, 1, 1); endtask
  task automatic reset_cyc(); drive(1, 0, 0, 0, 1, 0); endtask

  initial begin
    int saved_cnt;
    int wrap_exp[4] = '{1, 2, 3, 0};

    reset_cyc();
    reset_cyc();
    check("reset_phase", int'(ph_a), 0);

    // one full frame on the default-shaped instance
    start_cyc();
    done_seen = 0;
    for (int k = 0; k < 1 + DA + PAR + SA; k++) begin
      adv_cyc();
      idle_cyc();
    end
    check("single_frame_done", done_seen, 1);
    check("single_frame_cnt", int'(cnt_a), 1);

    // reset in the middle of DATA at bit 3
    start_cyc();
    for (int k = 0; k < 4; k++) adv_cyc();
    check("mid_data_idx", int'(idx_a), 3);
    reset_cyc();
    check("mid_rst_phase", int'(ph_a), 0);
    check("mid_rst_cnt", int'(cnt_a), 0);

    // tx_en low freezes the frame, BitDone pulses notwithstanding
    start_cyc();
    for (int k = 0; k < 6; k++) adv_cyc();
    for (int k = 0; k < 3; k++) drive(0, 1, 1, 0, 1, 0);
    check("freeze_idx", int'(idx_a), 5);
    adv_cyc();
    check("resume_idx", int'(idx_a), 6);

    // frame clear while in STOP
    for (int k = 0; k < 20 && ph_a != 3'd4; k++) adv_cyc();
    check("reach_stop", int'(ph_a), 4);
    saved_cnt = int'(cnt_a);
    drive(0, 1, 0, 1, 0, 0);
    check("clr_phase", int'(ph_a), 0);
    check("clr_no_done", int'(done_a), 0);
    check("clr_cnt", int'(cnt_a), saved_cnt);

    // counter wrap on the 2-bit instance, start held during the final STOP adv
    reset_cyc();
    for (int f = 0; f < 4; f++) begin
      start_cyc();
      for (int k = 0; k < DA + PAR + SA; k++) adv_cyc();
      drive(0, 1, 1, 1, 1, 1);
      check("wrap_cnt", int'(cnt_a), wrap_exp[f]);
      idle_cyc();
    end

    for (int c = 0; c < 3000; c++) begin
      bit r_rst, r_en, r_bd, r_tx, r_byc, r_st;
      r_rst = ($urandom_range(0, 63) == 0);
      r_en  = ($urandom_range(0, 3) != 0);
      r_bd  = $urandom_range(0, 1);
      r_tx  = ($urandom_range(0, 7) != 0);
      r_st  = ($urandom_range(0, 3) == 0);
      r_byc = !(r_tx && $urandom_range(0, 31) == 0);
      if (r_st) r_bd = 1'b0;
      drive(r_rst, r_en, r_bd, r_tx, r_byc, r_st);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
